// File: rtl/audio_pkg.sv
// Shared audio playback encodings: sample-reader FSM states, playback direction
// and the latched flash word. Also imported by the address counter.
package audio_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ_REQ  = 3'd1;
  localparam logic [2:0] S_READ_WAIT = 3'd2;
  localparam logic [2:0] S_TICK_A    = 3'd3;
  localparam logic [2:0] S_TICK_B    = 3'd4;
  localparam logic [2:0] S_ADV       = 3'd5;
  localparam logic [2:0] S_ADV_WAIT  = 3'd6;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic        dir;
  } word_lat_t;

  // Forward plays the low half first; reverse plays the high half first.
  function automatic logic [15:0] pick_half(word_lat_t w, logic first);
    return ((w.dir == DIR_FWD) == first) ? w.data[15:0] : w.data[31:16];
  endfunction

endpackage

// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read-only bus between the sample reader (master) and the flash controller.
interface flash_sample_reader_if #(parameter int AW = 23);
  logic          read;
  logic [AW-1:0] address;
  logic          waitrequest;
  logic [31:0]   readdata;
  logic          readdatavalid;

  modport master (output read, address, input waitrequest, readdata, readdatavalid);
  modport slave  (input read, address, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/flash_avalon_reader.sv
// Single-outstanding Avalon-MM read engine: holds read/address until accepted,
// then waits for readdatavalid. Data outside the wait phase is dropped.
module flash_avalon_reader #(
  parameter int AW = 23
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic [AW-1:0]                addr_i,
  output logic                         accept_o,
  output logic                         rvalid_o,
  output logic [31:0]                  rdata_o,
  flash_sample_reader_if.master        bus
);

  logic          read_q, read_d;
  logic          wait_q, wait_d;
  logic [AW-1:0] addr_q, addr_d;

  assign accept_o = read_q & ~bus.waitrequest;
  assign rvalid_o = wait_q & bus.readdatavalid;
  assign rdata_o  = bus.readdata;

  always_comb begin
    read_d = read_q;
    wait_d = wait_q;
    addr_d = addr_q;
    if (start_i && !read_q && !wait_q) begin
      read_d = 1'b1;
      addr_d = addr_i;
    end
    if (accept_o) begin
      read_d = 1'b0;
      wait_d = 1'b1;
    end
    if (rvalid_o) wait_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_q <= 1'b0;
      wait_q <= 1'b0;
      addr_q <= '0;
    end else begin
      read_q <= read_d;
      wait_q <= wait_d;
      addr_q <= addr_d;
    end
  end

  assign bus.read    = read_q;
  assign bus.address = addr_q;

endmodule

// File: rtl/flash_sample_reader.sv
// Streams 32-bit flash words as two 16-bit audio samples on sample_tick,
// then steps the external address counter and fetches the next word.
module flash_sample_reader
  import audio_pkg::*;
#(
  parameter int FLASH_AW    = 23,
  parameter int ACK_TIMEOUT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  dir,
  input  logic                  sample_tick,
  input  logic [31:0]           word_address,
  output logic                  next_addr_req,
  input  logic                  next_addr_ack,
  flash_sample_reader_if.master flash,
  output logic [15:0]           audio_sample,
  output logic                  sample_valid
);

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  word_lat_t     word_q, word_d;
  logic [15:0]   audio_q, audio_d;
  logic          sv_q, sv_d;
  logic          nreq_q, nreq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start, accept, rvalid, tick_ok;
  logic [31:0]   rdata;

  flash_avalon_reader #(.AW(FLASH_AW)) u_rd (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .addr_i   (word_address[FLASH_AW-1:0]),
    .accept_o (accept),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .bus      (flash)
  );

  generate
    if (FLASH_AW < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^word_address[31:FLASH_AW];
    end
  endgenerate

  assign tick_ok = sample_tick & play;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    audio_d = audio_q;
    sv_d    = 1'b0;
    nreq_d  = 1'b0;
    cnt_d   = cnt_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: if (play) begin
        state_d = S_READ_REQ;
        start   = 1'b1;
      end
      S_READ_REQ:  if (accept) state_d = S_READ_WAIT;
      S_READ_WAIT: if (rvalid) begin
        word_d.data = rdata;
        word_d.dir  = dir;
        state_d     = S_TICK_A;
      end
      S_TICK_A: if (tick_ok) begin
        audio_d = pick_half(word_q, 1'b1);
        sv_d    = 1'b1;
        state_d = S_TICK_B;
      end
      S_TICK_B: if (tick_ok) begin
        audio_d = pick_half(word_q, 1'b0);
        sv_d    = 1'b1;
        nreq_d  = 1'b1;
        state_d = S_ADV;
      end
      S_ADV: begin
        cnt_d   = '0;
        state_d = S_ADV_WAIT;
      end
      // The counter stays silent when it wraps, so the timeout is the fallback exit.
      S_ADV_WAIT: if (next_addr_ack || cnt_q == CNT_LAST) begin
        state_d = play ? S_READ_REQ : S_IDLE;
        start   = play;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      audio_q <= '0;
      sv_q    <= 1'b0;
      nreq_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      audio_q <= audio_d;
      sv_q    <= sv_d;
      nreq_q  <= nreq_d;
      cnt_q   <= cnt_d;
    end
  end

  assign next_addr_req = nreq_q;
  assign audio_sample  = audio_q;
  assign sample_valid  = sv_q;

endmodule

// File: doc/flash_sample_reader.md
FLASH_SAMPLE_READER -- requirements
Module: flash_sample_reader

Interface
REQ-001 Parameter FLASH_AW, default 23: width of the flash word address.
REQ-002 Parameter ACK_TIMEOUT, default 2: cycles to wait for next_addr_ack before proceeding.
REQ-003 clk  input  1  system clock, 50 MHz; reset  input  1  asynchronous, active-high.
REQ-004 play  input  1  playback enable, level.
REQ-005 dir  input  1  1 = forward (low half first), 0 = reverse (high half first).
REQ-006 sample_tick  input  1  single-cycle audio-rate strobe, synchronous to clk.
REQ-007 word_address  input  32  current flash word address from the address counter.
REQ-008 next_addr_req  output  1  single-cycle request to the address counter to step its address.
REQ-009 next_addr_ack  input  1  address counter has stepped.
REQ-010 flash_read  output  1  Avalon-MM read request.
REQ-011 flash_address  output  FLASH_AW  Avalon-MM word address.
REQ-012 flash_waitrequest  input  1  Avalon-MM stall.
REQ-013 flash_readdata  input  32  Avalon-MM read data.
REQ-014 flash_readdatavalid  input  1  Avalon-MM read data qualifier.
REQ-015 audio_sample  output  16  current signed audio sample, held between updates.
REQ-016 sample_valid  output  1  single-cycle pulse when audio_sample updates.

Function
REQ-017 FSM states SHALL be IDLE, READ_REQ, READ_WAIT, TICK_A, TICK_B, ADV, ADV_WAIT.
REQ-018 IDLE: play=1 -> READ_REQ; else remain.
REQ-019 READ_REQ: flash_read=1, flash_address=word_address[FLASH_AW-1:0]; both held stable until a cycle with flash_waitrequest=0 -> READ_WAIT.
REQ-020 READ_WAIT: flash_read=0; on flash_readdatavalid=1, latch flash_readdata and dir -> TICK_A.
REQ-021 readdatavalid outside READ_WAIT SHALL be ignored.
REQ-022 TICK_A: on sample_tick with play=1, audio_sample = data[15:0] (latched dir=1) or data[31:16] (latched dir=0), sample_valid=1 for one cycle -> TICK_B.
REQ-023 TICK_B: on sample_tick with play=1, output the other half, sample_valid=1 for one cycle -> ADV.
REQ-024 In TICK_A/TICK_B, sample_tick while play=0 SHALL be ignored (pause, state and audio_sample held).
REQ-025 ADV: next_addr_req=1 for exactly one cycle -> ADV_WAIT.
REQ-026 ADV_WAIT: on next_addr_ack=1 or after ACK_TIMEOUT cycles (counter does not acknowledge at wrap-around) -> READ_REQ if play=1, else IDLE.
REQ-027 next_addr_req SHALL never be high for two consecutive cycles.
REQ-028 audio_sample and sample_valid update registered, one cycle after the qualifying sample_tick.
REQ-029 Latched dir SHALL be used for both halves of a word; dir changes take effect on the next word.
REQ-030 No Avalon read SHALL be issued outside READ_REQ; at most one read outstanding.

Reset
REQ-031 On reset: state=IDLE, flash_read=0, flash_address=0, next_addr_req=0, audio_sample=0, sample_valid=0, latched data=0.
REQ-032 Reset mid-read SHALL abandon the transaction; a late readdatavalid after reset SHALL be ignored (state is IDLE).

Structure
REQ-033 State enum and direction encodings (FWD=1, REV=0) SHALL reside in shared package audio_pkg, also used by address_counter.
REQ-034 Avalon read handshake (READ_REQ/READ_WAIT) MAY be a sub-module flash_avalon_reader; the rest is one FSM.

Verification
REQ-035 Forward play: dir=1, word 0x1234ABCD, zero waitrequest, two ticks -> audio_sample 0xABCD then 0x1234, one next_addr_req pulse.
REQ-036 Reverse play: dir=0, same word -> 0x1234 then 0xABCD.
REQ-037 Stall: waitrequest high 5 cycles -> flash_read and flash_address stable 6 cycles, exactly one read accepted.
REQ-038 Pause: play=0 during TICK_B, 3 ticks -> no sample_valid, audio_sample unchanged; play=1 and next tick -> second half emitted.
REQ-039 Missing ack: next_addr_ack held 0 -> ADV_WAIT exits after ACK_TIMEOUT=2 cycles, new read issued.
REQ-040 Reset during READ_WAIT, readdatavalid 2 cycles later -> all outputs 0, state IDLE, no sample_valid.
